// File: rtl/shift_unit.sv
// Iterative shift/rotate register: parallel load, then one single-bit step per clock
// for a programmable count, sequenced by a START/BUSY/DONE handshake.
module shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               ser_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               ser_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100,
        OP_SLS = 3'b101,
        OP_SRS = 3'b110,
        OP_RSV = 3'b111
    } op_t;

    state_t             state_q, state_n;
    op_t                op_q, op_n;
    logic [SHAMT_W-1:0] count_q, count_n;
    logic [WIDTH-1:0]   data_q, data_n;
    logic               sout_q, sout_n;
    logic               done_q, done_n;

    logic [WIDTH-1:0]   step_data;
    logic               step_out;

    // One single-bit step of the latched operation.
    always_comb begin
        step_data = data_q;
        step_out  = sout_q;
        unique case (op_q)
            OP_SLL: begin step_data = {data_q[WIDTH-2:0], 1'b0};          step_out = data_q[WIDTH-1]; end
            OP_SRL: begin step_data = {1'b0, data_q[WIDTH-1:1]};          step_out = data_q[0];       end
            OP_SRA: begin step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]}; step_out = data_q[0];     end
            OP_ROL: begin step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]}; step_out = data_q[WIDTH-1]; end
            OP_ROR: begin step_data = {data_q[0], data_q[WIDTH-1:1]};     step_out = data_q[0];       end
            OP_SLS: begin step_data = {data_q[WIDTH-2:0], ser_in};        step_out = data_q[WIDTH-1]; end
            OP_SRS: begin step_data = {ser_in, data_q[WIDTH-1:1]};        step_out = data_q[0];       end
            default: begin step_data = data_q;                            step_out = sout_q;          end
        endcase
    end

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through this block infers a latch.
        state_n = state_q;
        op_n    = op_q;
        count_n = count_q;
        data_n  = data_q;
        sout_n  = sout_q;
        done_n  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    data_n = data_in;
                end else if (start) begin
                    op_n = op_t'(op);
                    // Zero count and the reserved code complete without ever going busy.
                    if (shamt == '0 || op_t'(op) == OP_RSV) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = SHIFT;
                        count_n = shamt;
                    end
                end
            end
            SHIFT: begin
                data_n  = step_data;
                sout_n  = step_out;
                count_n = count_q - 1'b1;
                if (count_q == SHAMT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_SLL;
            count_q <= '0;
            data_q  <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            count_q <= count_n;
            data_q  <= data_n;
            sout_q  <= sout_n;
            done_q  <= done_n;
        end
    end

    assign data_out = data_q;
    assign ser_out  = sout_q;
    assign busy     = (state_q == SHIFT);
    assign done     = done_q;

endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised iterative shift/rotate register, the next generation of the team's load-and-shift-by-one register. It holds a WIDTH-bit word that can be parallel-loaded or shifted by a programmable amount in one of seven modes, one bit position per clock. A START/BUSY/DONE handshake sequences each operation, and a serial port feeds in or captures the bits shifted across the boundary.

## Interface
- WIDTH, 32, data word width (≥ 2)
- SHAMT_W, 5, shift-amount width; maximum amount 2^SHAMT_W − 1
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- LOAD  input  1  parallel load request
- DATA_IN  input  WIDTH  parallel load data
- START  input  1  start shift operation (single-cycle pulse or level)
- OP  input  3  shift mode, sampled with START
- SHAMT  input  SHAMT_W  shift count, sampled with START
- SER_IN  input  1  serial fill bit for modes SLS/SRS, sampled every shift cycle
- DATA_OUT  output  WIDTH  register contents
- SER_OUT  output  1  last bit shifted/rotated out of the word
- BUSY  output  1  operation in progress
- DONE  output  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT. Reset: IDLE, DATA_OUT=0, SER_OUT=0, BUSY=0, DONE=0, count=0.
- IDLE, LOAD=1: DATA_OUT←DATA_IN at the edge; START ignored that cycle (LOAD wins); no DONE.
- IDLE, LOAD=0, START=1: latch OP and SHAMT. SHAMT=0 → stay IDLE, DATA_OUT unchanged, DONE=1 next cycle. SHAMT>0 → SHIFT, count←SHAMT.
- SHIFT: each edge performs one single-bit step per latched OP, count decrements; when count reaches 0 → IDLE, DONE=1 for one cycle.
- OP encoding (one step):
  - 000 SLL: {D[W-2:0],0}, out D[W-1]
  - 001 SRL: {0,D[W-1:1]}, out D[0]
  - 010 SRA: {D[W-1],D[W-1:1]}, out D[0]
  - 011 ROL: {D[W-2:0],D[W-1]}, out D[W-1]
  - 100 ROR: {D[0],D[W-1:1]}, out D[0]
  - 101 SLS: {D[W-2:0],SER_IN}, out D[W-1]
  - 110 SRS: {SER_IN,D[W-1:1]}, out D[0]
  - 111 reserved: completes as SHAMT=0 (no change, DONE next cycle)
- SER_OUT updates on every shift step with the "out" bit; holds otherwise (not changed by LOAD).
- While BUSY: LOAD, START, OP, SHAMT, DATA_IN ignored; only SER_IN is used.
- Amounts ≥ WIDTH are legal: SLL/SRL/SLS/SRS/SRA saturate naturally; rotates wrap (ROL by WIDTH = identity).
- RST_N low at any time, including mid-SHIFT: immediate clear to reset values, operation abandoned, no DONE.

## Timing
- LOAD: DATA_OUT valid one cycle after the sampling edge.
- START sampled at edge 0 with SHAMT=N>0: BUSY high after edge 0 through edge N; DATA_OUT reflects k steps after edge k; at edge N BUSY→0 and DONE→1 for exactly one cycle.
- SHAMT=0 or OP=111: BUSY never asserts; DONE high for the cycle after edge 0.
- New START accepted in the cycle DONE is high (back-to-back: zero idle gap).
- All outputs are registered; no combinational input-to-output paths.
- Reset deassertion is synchronised externally; first usable edge is the one after RST_N rises.

## Test plan
- Reset: RST_N=0 with LOAD=1, DATA_IN=F000_0001 → DATA_OUT=0000_0000, BUSY=0, DONE=0, SER_OUT=0.
- Load then SLL 1: LOAD F000_0001; START OP=000 SHAMT=1 → after 1 cycle DATA_OUT=E000_0002, SER_OUT=1, DONE pulses once, BUSY high exactly 1 cycle.
- Multi-step: LOAD 8000_0000, SRA 4 → F800_0000 after 4 cycles (intermediate C000_0000, E000_0000, F000_0000); LOAD F000_0001, ROL 4 → 0000_001F, SER_OUT=1.
- Serial fill and zero count: LOAD 0000_0001, SLS 3 with SER_IN=1 → 0000_000F; then START SHAMT=0 → DATA_OUT unchanged, DONE next cycle, BUSY stays 0.
- Collisions: LOAD=1 and START=1 together in IDLE → data loaded, no operation, no DONE; LOAD/START pulsed while BUSY → ignored, result unaffected; START during DONE cycle → accepted.
- Reset mid-operation and WIDTH=8 instance: RST_N low at step 2 of SRL 5 → all outputs 0 immediately, no DONE; WIDTH=8, SHAMT_W=3: LOAD A5, ROR 7 → 4B, SLL 7 of 4B → 80.
